// File: rtl/dcache_port_ctrl.sv
// rtl/dcache_port_ctrl.sv - per-port L1 data cache lookup and miss controller
//
// Purpose: accepts one load/store from a core port, looks it up in the shared
// set-associative arrays, serves hits locally and hands misses and
// uncacheable accesses to the shared miss handler.
//
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   bypass_i, busy_o         cache disable, controller not idle
//   address_*/data_*/kill_*  core request port (index first, tag later)
//   data_gnt/rvalid/rdata    core response port
//   req/addr/tag/we/...      tag/data array access, rdata_i/hit_way_i back
//   miss_*                   request to the shared miss handler
//   critical_word_*/bypass_* refill and bypass responses
//   mshr_*                   outstanding-miss address check
module dcache_port_ctrl #(
   parameter logic [63:0] CACHE_START_ADDR = 64'h8000_0000,
   parameter int SET_ASSOC   = 8,
   parameter int INDEX_WIDTH = 12,
   parameter int TAG_WIDTH   = 44,
   parameter int LINE_WIDTH  = 128
) (
   input  logic                              clk_i,
   input  logic                              rst_ni,
   input  logic                              bypass_i,
   output logic                              busy_o,
   input  logic [INDEX_WIDTH-1:0]            address_index_i,
   input  logic [TAG_WIDTH-1:0]              address_tag_i,
   input  logic                              tag_valid_i,
   input  logic                              data_req_i,
   input  logic                              data_we_i,
   input  logic [7:0]                        data_be_i,
   input  logic [1:0]                        data_size_i,
   input  logic [63:0]                       data_wdata_i,
   input  logic                              kill_req_i,
   output logic                              data_gnt_o,
   output logic                              data_rvalid_o,
   output logic [63:0]                       data_rdata_o,
   output logic [SET_ASSOC-1:0]              req_o,
   output logic [INDEX_WIDTH-1:0]            addr_o,
   output logic [TAG_WIDTH-1:0]              tag_o,
   output logic                              we_o,
   output logic [63:0]                       wdata_o,
   output logic [7:0]                        be_o,
   output logic                              dirty_o,
   input  logic                              gnt_i,
   input  logic [SET_ASSOC*LINE_WIDTH-1:0]   rdata_i,
   input  logic [SET_ASSOC-1:0]              hit_way_i,
   output logic                              miss_valid_o,
   output logic                              miss_bypass_o,
   output logic [TAG_WIDTH+INDEX_WIDTH-1:0]  miss_addr_o,
   output logic                              miss_we_o,
   output logic [63:0]                       miss_wdata_o,
   output logic [7:0]                        miss_be_o,
   output logic [1:0]                        miss_size_o,
   input  logic                              miss_gnt_i,
   input  logic                              active_serving_i,
   input  logic [63:0]                       critical_word_i,
   input  logic                              critical_word_valid_i,
   input  logic                              bypass_gnt_i,
   input  logic                              bypass_valid_i,
   input  logic [63:0]                       bypass_data_i,
   output logic [TAG_WIDTH+INDEX_WIDTH-1:0]  mshr_addr_o,
   input  logic                              mshr_addr_matches_i,
   input  logic                              mshr_index_matches_i
);

   localparam int ADDR_W = TAG_WIDTH + INDEX_WIDTH;
   localparam int WORDS  = LINE_WIDTH / 64;

   typedef enum logic [2:0] {
      IDLE, WAIT_TAG, STORE_REQ, WAIT_MSHR, WAIT_TAG_SAVED,
      WAIT_REFILL_GNT, WAIT_CRITICAL_WORD, WAIT_BYPASS_VALID
   } state_t;

   state_t                  state_q;
   logic [INDEX_WIDTH-1:0]  index_q;
   logic [TAG_WIDTH-1:0]    tag_q;
   logic                    we_q;
   logic [7:0]              be_q;
   logic [1:0]              size_q;
   logic [63:0]             wdata_q;
   logic                    bypass_q;
   logic [SET_ASSOC-1:0]    hit_way_q;
   logic                    saved_q;    // tag comes from tag_q after an MSHR re-read

   logic [TAG_WIDTH-1:0]    tag_eff;
   logic                    tag_ok;
   logic [ADDR_W-1:0]       line_addr;
   logic                    uncacheable;
   logic                    is_hit;
   logic [LINE_WIDTH-1:0]   hit_line;
   logic [LINE_WIDTH-1:0]   shifted_line;
   logic [INDEX_WIDTH-1:0]  word_idx;

   // These handler status inputs carry no information this port needs.
   logic unused_inputs;
   assign unused_inputs = active_serving_i ^ mshr_addr_matches_i;

   assign tag_eff     = saved_q ? tag_q : address_tag_i;
   assign tag_ok      = saved_q | tag_valid_i;
   assign line_addr   = {tag_eff, index_q};
   assign uncacheable = bypass_i || (64'(line_addr) < CACHE_START_ADDR);
   assign is_hit      = |hit_way_i;
   assign busy_o      = (state_q != IDLE);

   // Select the hit way's line, then the 64-bit word addressed by index[..:3].
   always_comb begin
      hit_line = '0;
      for (int w = 0; w < SET_ASSOC; w++) begin
         if (hit_way_i[w]) hit_line = hit_line | rdata_i[w*LINE_WIDTH +: LINE_WIDTH];
      end
   end
   assign word_idx     = (index_q >> 3) & INDEX_WIDTH'(WORDS - 1);
   assign shifted_line = hit_line >> {word_idx, 6'b0};

   always_comb begin
      data_gnt_o    = 1'b0;
      data_rvalid_o = 1'b0;
      data_rdata_o  = '0;
      req_o         = '0;
      addr_o        = index_q;
      tag_o         = tag_q;
      we_o          = 1'b0;
      wdata_o       = '0;
      be_o          = '0;
      dirty_o       = 1'b0;
      miss_valid_o  = 1'b0;
      miss_bypass_o = 1'b0;
      miss_addr_o   = '0;
      miss_we_o     = 1'b0;
      miss_wdata_o  = '0;
      miss_be_o     = '0;
      miss_size_o   = '0;
      mshr_addr_o   = {tag_q, index_q};
      case (state_q)
         IDLE: begin
            if (data_req_i) begin
               req_o      = '1;
               addr_o     = address_index_i;
               data_gnt_o = gnt_i;
            end
         end
         WAIT_TAG: begin
            tag_o       = tag_eff;
            mshr_addr_o = line_addr;
            if (kill_req_i) begin
               data_rvalid_o = 1'b1;
            end else if (tag_ok && !uncacheable && is_hit && !we_q) begin
               data_rvalid_o = 1'b1;
               data_rdata_o  = shifted_line[63:0];
            end
         end
         STORE_REQ: begin
            req_o   = hit_way_q;
            we_o    = 1'b1;
            wdata_o = wdata_q;
            be_o    = be_q;
            dirty_o = 1'b1;
         end
         WAIT_TAG_SAVED: begin
            req_o = '1;
            if (kill_req_i) data_rvalid_o = 1'b1;
         end
         WAIT_REFILL_GNT: begin
            miss_valid_o  = 1'b1;
            miss_bypass_o = bypass_q;
            miss_addr_o   = {tag_q, index_q};
            // Cached loads refill whole lines; align to the 64-bit word.
            if (!bypass_q && !we_q) miss_addr_o[2:0] = 3'b000;
            miss_we_o     = we_q;
            miss_wdata_o  = wdata_q;
            miss_be_o     = be_q;
            miss_size_o   = size_q;
         end
         WAIT_CRITICAL_WORD: begin
            if (critical_word_valid_i) begin
               data_rvalid_o = 1'b1;
               data_rdata_o  = critical_word_i;
            end
         end
         WAIT_BYPASS_VALID: begin
            if (bypass_valid_i) begin
               data_rvalid_o = 1'b1;
               data_rdata_o  = bypass_data_i;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= IDLE;
         index_q   <= '0;
         tag_q     <= '0;
         we_q      <= 1'b0;
         be_q      <= '0;
         size_q    <= '0;
         wdata_q   <= '0;
         bypass_q  <= 1'b0;
         hit_way_q <= '0;
         saved_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (data_req_i && gnt_i) begin
                  index_q <= address_index_i;
                  we_q    <= data_we_i;
                  be_q    <= data_be_i;
                  size_q  <= data_size_i;
                  wdata_q <= data_wdata_i;
                  saved_q <= 1'b0;
                  state_q <= WAIT_TAG;
               end
            end
            WAIT_TAG: begin
               if (kill_req_i) begin
                  state_q <= IDLE;
               end else if (tag_ok) begin
                  tag_q    <= tag_eff;
                  bypass_q <= uncacheable;
                  if (uncacheable)              state_q <= WAIT_REFILL_GNT;
                  else if (is_hit && !we_q)     state_q <= IDLE;
                  else if (is_hit) begin
                     hit_way_q <= hit_way_i;
                     state_q   <= STORE_REQ;
                  end
                  else if (mshr_index_matches_i) state_q <= WAIT_MSHR;
                  else                           state_q <= WAIT_REFILL_GNT;
               end
            end
            STORE_REQ: if (gnt_i) state_q <= IDLE;
            WAIT_MSHR: if (!mshr_index_matches_i) state_q <= WAIT_TAG_SAVED;
            WAIT_TAG_SAVED: begin
               if (kill_req_i) begin
                  state_q <= IDLE;
               end else if (gnt_i) begin
                  saved_q <= 1'b1;
                  state_q <= WAIT_TAG;
               end
            end
            WAIT_REFILL_GNT: begin
               if (bypass_q) begin
                  if (bypass_gnt_i) state_q <= WAIT_BYPASS_VALID;
               end else if (miss_gnt_i) begin
                  state_q <= we_q ? IDLE : WAIT_CRITICAL_WORD;
               end
            end
            WAIT_CRITICAL_WORD: if (critical_word_valid_i) state_q <= IDLE;
            WAIT_BYPASS_VALID:  if (bypass_valid_i) state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dcache_port_ctrl.sv
// tb/tb_dcache_port_ctrl.sv - directed scoreboard bench for dcache_port_ctrl
module tb_dcache_port_ctrl;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic          bypass_i = 0;
   logic          busy_o;
   logic [11:0]   address_index_i = 0;
   logic [43:0]   address_tag_i = 0;
   logic          tag_valid_i = 0;
   logic          data_req_i = 0;
   logic          data_we_i = 0;
   logic [7:0]    data_be_i = 0;
   logic [1:0]    data_size_i = 0;
   logic [63:0]   data_wdata_i = 0;
   logic          kill_req_i = 0;
   logic          data_gnt_o;
   logic          data_rvalid_o;
   logic [63:0]   data_rdata_o;
   logic [7:0]    req_o;
   logic [11:0]   addr_o;
   logic [43:0]   tag_o;
   logic          we_o;
   logic [63:0]   wdata_o;
   logic [7:0]    be_o;
   logic          dirty_o;
   logic          gnt_i = 0;
   logic [1023:0] rdata_i = '0;
   logic [7:0]    hit_way_i = 0;
   logic          miss_valid_o;
   logic          miss_bypass_o;
   logic [55:0]   miss_addr_o;
   logic          miss_we_o;
   logic [63:0]   miss_wdata_o;
   logic [7:0]    miss_be_o;
   logic [1:0]    miss_size_o;
   logic          miss_gnt_i = 0;
   logic          active_serving_i = 0;
   logic [63:0]   critical_word_i = 0;
   logic          critical_word_valid_i = 0;
   logic          bypass_gnt_i = 0;
   logic          bypass_valid_i = 0;
   logic [63:0]   bypass_data_i = 0;
   logic [55:0]   mshr_addr_o;
   logic          mshr_addr_matches_i = 0;
   logic          mshr_index_matches_i = 0;

   dcache_port_ctrl dut (
      .clk_i(clk), .rst_ni(rst_n), .bypass_i(bypass_i), .busy_o(busy_o),
      .address_index_i(address_index_i), .address_tag_i(address_tag_i),
      .tag_valid_i(tag_valid_i), .data_req_i(data_req_i), .data_we_i(data_we_i),
      .data_be_i(data_be_i), .data_size_i(data_size_i), .data_wdata_i(data_wdata_i),
      .kill_req_i(kill_req_i), .data_gnt_o(data_gnt_o), .data_rvalid_o(data_rvalid_o),
      .data_rdata_o(data_rdata_o), .req_o(req_o), .addr_o(addr_o), .tag_o(tag_o),
      .we_o(we_o), .wdata_o(wdata_o), .be_o(be_o), .dirty_o(dirty_o), .gnt_i(gnt_i),
      .rdata_i(rdata_i), .hit_way_i(hit_way_i), .miss_valid_o(miss_valid_o),
      .miss_bypass_o(miss_bypass_o), .miss_addr_o(miss_addr_o), .miss_we_o(miss_we_o),
      .miss_wdata_o(miss_wdata_o), .miss_be_o(miss_be_o), .miss_size_o(miss_size_o),
      .miss_gnt_i(miss_gnt_i), .active_serving_i(active_serving_i),
      .critical_word_i(critical_word_i), .critical_word_valid_i(critical_word_valid_i),
      .bypass_gnt_i(bypass_gnt_i), .bypass_valid_i(bypass_valid_i),
      .bypass_data_i(bypass_data_i), .mshr_addr_o(mshr_addr_o),
      .mshr_addr_matches_i(mshr_addr_matches_i), .mshr_index_matches_i(mshr_index_matches_i)
   );

   int errors = 0;
   int checks = 0;
   int rv_count = 0;
   // bit 64 set: response expected but its data is not defined (kill)
   logic [64:0] sb[$];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   always @(negedge clk) begin
      if (rst_n && data_rvalid_o) begin
         logic [64:0] e;
         rv_count++;
         chk("rvalid_expected", 64'(sb.size() != 0), 64'd1);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            if (!e[64]) chk("rdata", data_rdata_o, e[63:0]);
         end
      end
   end

   task automatic grant_req(input logic [11:0] idx, input logic we, input logic [63:0] wd);
      tick();
      data_req_i = 1; gnt_i = 1; address_index_i = idx;
      data_we_i = we; data_wdata_i = wd; data_be_i = 8'hFF; data_size_i = 2'd3;
      smp();
      chk("gnt", 64'(data_gnt_o), 64'd1);
      chk("req_all_ways", 64'(req_o), 64'hFF);
      chk("req_addr", 64'(addr_o), 64'(idx));
      tick();
      data_req_i = 0; gnt_i = 0;
   endtask

   task automatic wait_drain(input string tag);
      int n = 0;
      while (sb.size() != 0 && n < 20) begin
         smp();
         n++;
      end
      chk(tag, 64'(sb.size()), 64'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1);
   end

   initial begin
      // reset
      smp();
      chk("rst_gnt", 64'(data_gnt_o), 0);
      chk("rst_rvalid", 64'(data_rvalid_o), 0);
      chk("rst_req", 64'(req_o), 0);
      chk("rst_we", 64'(we_o), 0);
      chk("rst_miss_valid", 64'(miss_valid_o), 0);
      chk("rst_busy", 64'(busy_o), 0);
      tick();
      rst_n = 1;

      // load hit: way 2, index 0x040 selects the low word
      rdata_i[2*128 +: 128] = {64'hBBBB, 64'hAAAA};
      sb.push_back({1'b0, 64'hAAAA});
      grant_req(12'h040, 0, 0);
      address_tag_i = 44'h80001; tag_valid_i = 1; hit_way_i = 8'b0000_0100;
      smp();
      chk("hit_rvalid", 64'(data_rvalid_o), 1);
      chk("hit_busy", 64'(busy_o), 1);
      tick();
      tag_valid_i = 0; hit_way_i = 0;
      smp();
      chk("hit_rvalid_pulse", 64'(data_rvalid_o), 0);
      chk("hit_idle", 64'(busy_o), 0);
      wait_drain("hit_drain");

      // store hit: way 4
      grant_req(12'h048, 1, 64'h1234);
      address_tag_i = 44'h80001; tag_valid_i = 1; hit_way_i = 8'h10;
      smp();
      chk("st_no_rvalid", 64'(data_rvalid_o), 0);
      tick();
      tag_valid_i = 0; hit_way_i = 0;
      smp();
      chk("st_req_way", 64'(req_o), 64'h10);
      chk("st_we", 64'(we_o), 1);
      chk("st_dirty", 64'(dirty_o), 1);
      chk("st_wdata", wdata_o, 64'h1234);
      chk("st_be", 64'(be_o), 64'hFF);
      chk("st_addr", 64'(addr_o), 64'h048);
      tick();
      gnt_i = 1;
      smp();
      chk("st_we_hold", 64'(we_o), 1);
      tick();
      gnt_i = 0;
      smp();
      chk("st_idle", 64'(busy_o), 0);
      chk("st_we_off", 64'(we_o), 0);

      // cached load miss with misaligned index: address aligned to the word
      sb.push_back({1'b0, 64'hCAFE});
      grant_req(12'h05C, 0, 0);
      address_tag_i = 44'h80002; tag_valid_i = 1; hit_way_i = 0;
      smp();
      chk("miss_no_rvalid", 64'(data_rvalid_o), 0);
      tick();
      tag_valid_i = 0;
      smp();
      chk("miss_addr", 64'(miss_addr_o), 64'h80002058);
      chk("miss_not_bypass", 64'(miss_bypass_o), 0);
      for (int i = 0; i < 3; i++) begin
         chk("miss_valid_hold", 64'(miss_valid_o), 1);
         smp();
      end
      tick();
      miss_gnt_i = 1;
      smp();
      chk("miss_valid_at_gnt", 64'(miss_valid_o), 1);
      tick();
      miss_gnt_i = 0;
      smp();
      chk("miss_valid_drop", 64'(miss_valid_o), 0);
      chk("miss_busy", 64'(busy_o), 1);
      tick();
      critical_word_i = 64'hCAFE; critical_word_valid_i = 1;
      smp();
      chk("cw_rvalid", 64'(data_rvalid_o), 1);
      tick();
      critical_word_valid_i = 0;
      wait_drain("miss_drain");

      // bypass: address 0x1000 below the cacheable region
      sb.push_back({1'b0, 64'h55});
      grant_req(12'h000, 0, 0);
      address_tag_i = 44'h1; tag_valid_i = 1;
      smp();
      chk("byp_no_rvalid", 64'(data_rvalid_o), 0);
      tick();
      tag_valid_i = 0;
      smp();
      chk("byp_miss_valid", 64'(miss_valid_o), 1);
      chk("byp_flag", 64'(miss_bypass_o), 1);
      chk("byp_addr", 64'(miss_addr_o), 64'h1000);
      tick();
      bypass_gnt_i = 1;
      smp();
      tick();
      bypass_gnt_i = 0;
      smp();
      chk("byp_miss_valid_drop", 64'(miss_valid_o), 0);
      tick();
      bypass_data_i = 64'h55; bypass_valid_i = 1;
      smp();
      chk("byp_rvalid", 64'(data_rvalid_o), 1);
      tick();
      bypass_valid_i = 0;
      smp();
      chk("byp_idle", 64'(busy_o), 0);
      wait_drain("byp_drain");

      // MSHR index conflict for 5 cycles, then re-read with the saved tag
      rdata_i[0 +: 128] = {64'h88, 64'h77};
      sb.push_back({1'b0, 64'h77});
      grant_req(12'h060, 0, 0);
      address_tag_i = 44'h80003; tag_valid_i = 1; hit_way_i = 0; mshr_index_matches_i = 1;
      smp();
      chk("mshr_addr_tag", 64'(mshr_addr_o), 64'h80003060);
      tick();
      tag_valid_i = 0; address_tag_i = 0;
      for (int i = 0; i < 4; i++) begin
         smp();
         chk("mshr_busy", 64'(busy_o), 1);
         chk("mshr_no_miss", 64'(miss_valid_o), 0);
         chk("mshr_no_req", 64'(req_o), 0);
         chk("mshr_addr_hold", 64'(mshr_addr_o), 64'h80003060);
         tick();
      end
      mshr_index_matches_i = 0;
      smp();
      tick();
      gnt_i = 1;
      smp();
      chk("reread_req", 64'(req_o), 64'hFF);
      chk("reread_addr", 64'(addr_o), 64'h060);
      chk("reread_tag", 64'(tag_o), 64'h80003);
      chk("reread_no_rvalid", 64'(data_rvalid_o), 0);
      tick();
      gnt_i = 0; hit_way_i = 8'b0000_0001;
      smp();
      chk("reread_rvalid", 64'(data_rvalid_o), 1);
      tick();
      hit_way_i = 0;
      smp();
      chk("reread_idle", 64'(busy_o), 0);
      wait_drain("mshr_drain");

      // kill together with tag valid and a would-be hit: kill wins
      sb.push_back({1'b1, 64'h0});
      grant_req(12'h070, 0, 0);
      address_tag_i = 44'h80004; tag_valid_i = 1; kill_req_i = 1; hit_way_i = 8'b0000_0001;
      smp();
      chk("kill_rvalid", 64'(data_rvalid_o), 1);
      tick();
      kill_req_i = 0; tag_valid_i = 0; hit_way_i = 0;
      smp();
      chk("kill_idle", 64'(busy_o), 0);
      chk("kill_rvalid_pulse", 64'(data_rvalid_o), 0);
      chk("kill_no_miss", 64'(miss_valid_o), 0);
      chk("kill_no_req", 64'(req_o), 0);

      wait_drain("final_drain");
      chk("rvalid_count", 64'(rv_count), 64'd5);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
